// File: rtl/csr_file_pkg.sv
// CSR address map and WARL write masks for the machine-mode CSR file.
// Shared by the CSR file and its counters.
package pack;

    typedef enum logic [11:0] {
        MSTATUS  = 12'h300,
        MISA     = 12'h301,
        MIE      = 12'h304,
        MTVEC    = 12'h305,
        MSCRATCH = 12'h340,
        MEPC     = 12'h341,
        MCAUSE   = 12'h342,
        MTVAL    = 12'h343,
        MIP      = 12'h344,
        MCYCLE   = 12'hB00,
        MINSTRET = 12'hB02
    } destinationCSR_;

    localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;
    localparam logic [31:0] MSTATUS_FIXED = 32'h0000_1800;
    localparam logic [31:0] MIE_WMASK     = 32'h0000_0888;
    localparam logic [31:0] ALIGN_MASK    = 32'hFFFF_FFFC;

    function automatic logic isWritable(input destinationCSR_ a);
        unique case (a)
            MSTATUS, MIE, MTVEC, MSCRATCH, MEPC,
            MCAUSE, MTVAL, MCYCLE, MINSTRET: isWritable = 1'b1;
            default:                         isWritable = 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] warlMask(
        input destinationCSR_ a,
        input logic [31:0]    d
    );
        unique case (a)
            MSTATUS:     warlMask = (d & MSTATUS_WMASK) | MSTATUS_FIXED;
            MIE:         warlMask = d & MIE_WMASK;
            MTVEC, MEPC: warlMask = d & ALIGN_MASK;
            default:     warlMask = d;
        endcase
    endfunction

endpackage

// File: rtl/csr_file_counter.sv
// Loadable wrapping counter backing mcycle and minstret.
// A load in the same cycle takes precedence over the increment.
module csr_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             increment,
    input  logic             load,
    input  logic [WIDTH-1:0] loadValue,
    output logic [WIDTH-1:0] value
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            value <= '0;
        end else if (load) begin
            value <= loadValue;
        end else if (increment) begin
            value <= value + WIDTH'(1);
        end
    end

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: combinational reads with write bypass,
// WARL writes, trap/mret bookkeeping and interrupt pending logic.
module csr_file
    import pack::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] MISA_VALUE  = 32'h4000_0100
) (
    input  logic           clock,
    input  logic           reset,
    input  destinationCSR_ readAddress,
    output logic [31:0]    readData,
    input  logic           writeEnable,
    input  destinationCSR_ writeAddress,
    input  logic [31:0]    writeData,
    input  logic           retire,
    input  logic           trapValid,
    input  logic [31:0]    trapCause,
    input  logic [31:0]    trapPC,
    input  logic [31:0]    trapValue,
    input  logic           mretValid,
    input  logic           softwareIrq,
    input  logic           timerIrq,
    input  logic           externalIrq,
    output logic [31:0]    trapVector,
    output logic [31:0]    returnPC,
    output logic           interruptPending
);

    logic [31:0] mstatus, mie, mip, mtvec, mepc;
    logic [31:0] mscratch, mcause, mtval;
    logic [31:0] mcycle, minstret;
    logic [31:0] wdMasked;

    assign wdMasked = warlMask(writeAddress, writeData);

    function automatic logic hit(input destinationCSR_ a);
        hit = writeEnable && (writeAddress == a);
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mstatus  <= MSTATUS_FIXED;
            mie      <= '0;
            mip      <= '0;
            mtvec    <= MTVEC_RESET;
            mepc     <= '0;
            mscratch <= '0;
            mcause   <= '0;
            mtval    <= '0;
        end else begin
            mip <= {20'd0, externalIrq, 3'd0, timerIrq, 3'd0, softwareIrq, 3'd0};
            if (hit(MIE))      mie      <= wdMasked;
            if (hit(MTVEC))    mtvec    <= wdMasked;
            if (hit(MSCRATCH)) mscratch <= wdMasked;
            if (trapValid) begin
                mepc       <= trapPC & ALIGN_MASK;
                mcause     <= trapCause;
                mtval      <= trapValue;
                mstatus[7] <= mstatus[3];
                mstatus[3] <= 1'b0;
            end else begin
                if (hit(MEPC))   mepc   <= wdMasked;
                if (hit(MCAUSE)) mcause <= wdMasked;
                if (hit(MTVAL))  mtval  <= wdMasked;
                if (mretValid) begin
                    mstatus[3] <= mstatus[7];
                    mstatus[7] <= 1'b1;
                end else if (hit(MSTATUS)) begin
                    mstatus <= wdMasked;
                end
            end
        end
    end

    csr_counter #(.WIDTH(32)) mcycleCounter (
        .clock     (clock),
        .reset     (reset),
        .increment (1'b1),
        .load      (hit(MCYCLE)),
        .loadValue (wdMasked),
        .value     (mcycle)
    );

    csr_counter #(.WIDTH(32)) minstretCounter (
        .clock     (clock),
        .reset     (reset),
        .increment (retire),
        .load      (hit(MINSTRET)),
        .loadValue (wdMasked),
        .value     (minstret)
    );

    always_comb begin
        readData = '0;
        unique case (readAddress)
            MSTATUS:  readData = mstatus;
            MISA:     readData = MISA_VALUE;
            MIE:      readData = mie;
            MTVEC:    readData = mtvec;
            MSCRATCH: readData = mscratch;
            MEPC:     readData = mepc;
            MCAUSE:   readData = mcause;
            MTVAL:    readData = mtval;
            MIP:      readData = mip;
            MCYCLE:   readData = mcycle;
            MINSTRET: readData = minstret;
            default:  readData = '0;
        endcase
        // Ignored writes (mip, misa, unmapped) must not bypass.
        if (hit(readAddress) && isWritable(readAddress)) begin
            readData = wdMasked;
        end
    end

    assign trapVector       = mtvec & ALIGN_MASK;
    assign returnPC         = mepc;
    assign interruptPending = mstatus[3] && |(mip & mie);

endmodule

// File: tb/tb_csr_file.sv
// Directed self-checking bench for csr_file: WARL table plus
// hand sequences for counters, interrupts, traps, mret and reset.
module tb_csr_file;
    import pack::*;

    logic           clock = 1'b0;
    logic           reset;
    destinationCSR_ readAddress;
    logic [31:0]    readData;
    logic           writeEnable;
    destinationCSR_ writeAddress;
    logic [31:0]    writeData;
    logic           retire;
    logic           trapValid;
    logic [31:0]    trapCause, trapPC, trapValue;
    logic           mretValid;
    logic           softwareIrq, timerIrq, externalIrq;
    logic [31:0]    trapVector, returnPC;
    logic           interruptPending;

    int total = 0;
    int bad   = 0;

    always #50 clock = ~clock;

    csr_file dut (
        .clock            (clock),
        .reset            (reset),
        .readAddress      (readAddress),
        .readData         (readData),
        .writeEnable      (writeEnable),
        .writeAddress     (writeAddress),
        .writeData        (writeData),
        .retire           (retire),
        .trapValid        (trapValid),
        .trapCause        (trapCause),
        .trapPC           (trapPC),
        .trapValue        (trapValue),
        .mretValid        (mretValid),
        .softwareIrq      (softwareIrq),
        .timerIrq         (timerIrq),
        .externalIrq      (externalIrq),
        .trapVector       (trapVector),
        .returnPC         (returnPC),
        .interruptPending (interruptPending)
    );

    typedef struct {
        destinationCSR_ addr;
        logic [31:0]    data;
        logic [31:0]    exp;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chkCsr(input string name, input destinationCSR_ a,
                          input logic [31:0] exp);
        readAddress = a;
        #1;
        check(name, readData, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input destinationCSR_ a, input logic [31:0] d);
        writeEnable  = 1'b1;
        writeAddress = a;
        writeData    = d;
    endtask

    initial begin
        vecs[0]  = '{MSTATUS,  32'hFFFF_FFFF, 32'h0000_1888};
        vecs[1]  = '{MSTATUS,  32'h0000_0000, 32'h0000_1800};
        vecs[2]  = '{MIE,      32'hFFFF_FFFF, 32'h0000_0888};
        vecs[3]  = '{MEPC,     32'hFFFF_FFFF, 32'hFFFF_FFFC};
        vecs[4]  = '{MSCRATCH, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[5]  = '{MCAUSE,   32'h0000_000B, 32'h0000_000B};
        vecs[6]  = '{MTVAL,    32'hCAFE_F00D, 32'hCAFE_F00D};
        vecs[7]  = '{MISA,     32'h0000_0000, 32'h4000_0100};
        vecs[8]  = '{MIP,      32'hFFFF_FFFF, 32'h0000_0000};
        vecs[9]  = '{destinationCSR_'(12'h7C0), 32'hFFFF_FFFF, 32'h0};
        vecs[10] = '{MINSTRET, 32'h0000_0055, 32'h0000_0055};
        vecs[11] = '{MIE,      32'h0000_0000, 32'h0000_0000};
        vecs[12] = '{MTVEC,    32'h1234_5677, 32'h1234_5674};

        reset = 1'b1;
        readAddress = MSTATUS;
        writeEnable = 1'b0;
        writeAddress = MSTATUS;
        writeData = '0;
        retire = 1'b0;
        trapValid = 1'b0;
        trapCause = '0;
        trapPC = '0;
        trapValue = '0;
        mretValid = 1'b0;
        softwareIrq = 1'b0;
        timerIrq = 1'b0;
        externalIrq = 1'b0;
        #2 reset = 1'b0;
        #2;
        chkCsr("rst_mstatus", MSTATUS, 32'h0000_1800);
        chkCsr("rst_mtvec", MTVEC, 32'h0);
        chkCsr("rst_mcycle", MCYCLE, 32'h0);
        check("rst_pending", {31'd0, interruptPending}, 32'h0);

        tick();
        tick();
        reset = 1'b1;
        repeat (10) tick();
        chkCsr("mcycle_10", MCYCLE, 32'd10);
        chkCsr("mstatus_idle", MSTATUS, 32'h0000_1800);

        for (int i = 0; i < 13; i++) begin
            wr(vecs[i].addr, vecs[i].data);
            readAddress = vecs[i].addr;
            #1;
            check($sformatf("bypass_%0d", i), readData, vecs[i].exp);
            tick();
            writeEnable = 1'b0;
            chkCsr($sformatf("readback_%0d", i), vecs[i].addr, vecs[i].exp);
        end
        check("trapVector", trapVector, 32'h1234_5674);

        wr(MCYCLE, 32'hFFFF_FFFF);
        tick();
        writeEnable = 1'b0;
        chkCsr("mcycle_load", MCYCLE, 32'hFFFF_FFFF);
        tick();
        chkCsr("mcycle_wrap", MCYCLE, 32'h0);

        wr(MINSTRET, 32'h10);
        retire = 1'b1;
        tick();
        writeEnable = 1'b0;
        retire = 1'b0;
        chkCsr("minstret_wr_wins", MINSTRET, 32'h10);
        retire = 1'b1;
        tick();
        retire = 1'b0;
        chkCsr("minstret_inc", MINSTRET, 32'h11);
        wr(MINSTRET, 32'hFFFF_FFFF);
        tick();
        writeEnable = 1'b0;
        retire = 1'b1;
        tick();
        retire = 1'b0;
        chkCsr("minstret_wrap", MINSTRET, 32'h0);

        wr(MSTATUS, 32'h8);
        tick();
        wr(MIE, 32'h80);
        tick();
        writeEnable = 1'b0;
        #1;
        check("irq_idle", {31'd0, interruptPending}, 32'h0);
        timerIrq = 1'b1;
        #1;
        check("irq_same_cycle", {31'd0, interruptPending}, 32'h0);
        tick();
        check("irq_next_cycle", {31'd0, interruptPending}, 32'h1);
        chkCsr("mip_timer", MIP, 32'h80);

        trapValid = 1'b1;
        trapPC = 32'h0000_0106;
        trapCause = 32'h8000_0007;
        trapValue = 32'h0000_55AA;
        tick();
        trapValid = 1'b0;
        timerIrq = 1'b0;
        chkCsr("trap_mepc", MEPC, 32'h0000_0104);
        check("trap_returnPC", returnPC, 32'h0000_0104);
        chkCsr("trap_mcause", MCAUSE, 32'h8000_0007);
        chkCsr("trap_mtval", MTVAL, 32'h0000_55AA);
        chkCsr("trap_mstatus", MSTATUS, 32'h0000_1880);
        check("trap_pending", {31'd0, interruptPending}, 32'h0);

        mretValid = 1'b1;
        tick();
        mretValid = 1'b0;
        chkCsr("mret_mstatus", MSTATUS, 32'h0000_1888);

        trapValid = 1'b1;
        trapPC = 32'h0000_0208;
        trapCause = 32'h0000_0002;
        mretValid = 1'b1;
        wr(MEPC, 32'h40);
        tick();
        trapValid = 1'b0;
        mretValid = 1'b0;
        writeEnable = 1'b0;
        chkCsr("prio_mepc", MEPC, 32'h0000_0208);
        check("prio_returnPC", returnPC, 32'h0000_0208);
        chkCsr("prio_mcause", MCAUSE, 32'h0000_0002);
        chkCsr("prio_mstatus", MSTATUS, 32'h0000_1880);

        reset = 1'b0;
        #1;
        chkCsr("arst_mstatus", MSTATUS, 32'h0000_1800);
        chkCsr("arst_mepc", MEPC, 32'h0);
        chkCsr("arst_mcycle", MCYCLE, 32'h0);
        check("arst_trapVector", trapVector, 32'h0);
        check("arst_pending", {31'd0, interruptPending}, 32'h0);
        tick();
        reset = 1'b1;
        repeat (3) tick();
        chkCsr("resume_mcycle", MCYCLE, 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/csr_file.md
CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 SHALL have parameter MTVEC_RESET, default 32'h0000_0000, giving the mtvec value after reset.
REQ-002 SHALL have parameter MISA_VALUE, default 32'h4000_0100 (RV32I), returned on misa reads.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 readAddress  input  destinationCSR_ (12)  CSR read address driven by the execute stage.
REQ-006 readData  output  32  current value of the CSR at readAddress, to the execute stage.
REQ-007 writeEnable  input  1  commit of a CSR write from writeback (valid && CSRWriteIntent).
REQ-008 writeAddress  input  destinationCSR_ (12)  CSR to write.
REQ-009 writeData  input  32  new value, already op-resolved (RW/RS/RC) upstream.
REQ-010 retire  input  1  one instruction retired this cycle.
REQ-011 trapValid  input  1  take a trap this cycle.
REQ-012 trapCause, trapPC, trapValue  input  32 each  mcause, faulting PC, mtval for the trap.
REQ-013 mretValid  input  1  mret committing this cycle.
REQ-014 softwareIrq, timerIrq, externalIrq  input  1 each  raw interrupt lines.
REQ-015 trapVector  output  32  {mtvec[31:2],2'b00}, fetch redirect target on trap.
REQ-016 returnPC  output  32  mepc, fetch redirect target on mret.
REQ-017 interruptPending  output  1  enabled interrupt pending and mstatus.MIE set.

Function
REQ-018 Reads SHALL be combinational; MSTATUS, MIE, MIP, MTVEC, MEPC, MSCRATCH, MCAUSE, MTVAL, MCYCLE, MINSTRET, MISA supported; any other address reads 32'd0.
REQ-019 Same-cycle writeEnable with writeAddress==readAddress SHALL bypass: readData = masked writeData.
REQ-020 Writes SHALL be WARL-masked: mstatus keeps only bits 3, 7 with [12:11] fixed 2'b11; mie keeps 3, 7, 11; mtvec/mepc force [1:0]=0; writes to mip, misa, unknown addresses ignored.
REQ-021 mcycle SHALL increment by 1 every cycle out of reset, wrapping 32'hFFFF_FFFF -> 0; a write to mcycle that cycle wins over the increment.
REQ-022 minstret SHALL increment on retire, wrapping likewise; a same-cycle write wins.
REQ-023 mip[3], mip[7], mip[11] SHALL register softwareIrq, timerIrq, externalIrq (one-cycle latency).
REQ-024 interruptPending = mstatus[3] && |(mip & mie), combinational from registered state.
REQ-025 On trapValid: mepc <= {trapPC[31:2],2'b00}, mcause <= trapCause, mtval <= trapValue, mstatus[7] <= mstatus[3], mstatus[3] <= 0, next cycle.
REQ-026 On mretValid (no trap): mstatus[3] <= mstatus[7], mstatus[7] <= 1.
REQ-027 Priority per cycle: trapValid > mretValid > writeEnable for every field each touches; untouched fields still take the lower-priority update.
REQ-028 trapVector and returnPC SHALL reflect registered state only (no same-cycle bypass).

Reset
REQ-029 Assertion of reset SHALL immediately set mstatus=32'h0000_1800, mtvec=MTVEC_RESET, all other state 0; interruptPending=0; deassertion mid-operation resumes counting from 0 next edge.

Structure
REQ-030 destinationCSR_ enum (CSR addresses) and WARL mask constants SHALL live in pack; no new typedefs local to the module.
REQ-031 One sub-module csr_counter (32-bit counter with increment enable and load port) SHALL be instantiated for mcycle and minstret.

Verification
REQ-032 Release reset, read MCYCLE at cycle 10 -> 32'd10 (+/-0 relative to first edge); MSTATUS -> 32'h1800.
REQ-033 Write MSTATUS=32'hFFFF_FFFF -> read 32'h0000_1888; same-cycle read of MSTATUS returns 32'h1888.
REQ-034 mstatus.MIE=1, mie=32'h80, raise timerIrq -> interruptPending=1 exactly one cycle later.
REQ-035 trapValid with trapPC=32'h0000_0106, cause 32'h8000_0007 -> mepc=32'h104, mcause set, MIE=0, MPIE=1; then mretValid -> MIE=1, MPIE=1.
REQ-036 trapValid, mretValid, and write MEPC=32'h40 in one cycle -> mepc from trap, MEPC write discarded; mcycle preloaded 32'hFFFF_FFFF wraps to 0.
